// File: rtl/tone_channel_arbiter.sv
// Arbitrates the single tone channel between free-play, auto-play and learning sources.
// Mode switches insert a silent gap; output changes are held for a minimum time.
module tone_channel_arbiter #(
  parameter int unsigned NOTE_W      = 5,
  parameter int unsigned MUTE_CYCLES = 16,
  parameter int unsigned MIN_HOLD    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        mode_in,
  input  logic [2:0]        req,
  input  logic [NOTE_W-1:0] note_free,
  input  logic [NOTE_W-1:0] note_auto,
  input  logic [NOTE_W-1:0] note_learn,
  output logic [2:0]        gnt,
  output logic [NOTE_W-1:0] note_out,
  output logic              note_en,
  output logic [2:0]        mode_cur,
  output logic              switching
);

  localparam int unsigned MuteW = (MUTE_CYCLES > 1) ? $clog2(MUTE_CYCLES) : 1;
  localparam int unsigned HoldW = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
  localparam logic [MuteW-1:0] MuteLoad = MuteW'(MUTE_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(MIN_HOLD - 1);

  typedef enum logic [1:0] {StIdle, StMute, StActive} state_e;

  state_e              state_q, state_d;
  logic [2:0]          mode_q;
  logic [2:0]          mode_cur_q, mode_cur_d;
  logic [MuteW-1:0]    mute_cnt_q, mute_cnt_d;
  logic [HoldW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [2:0]          gnt_q, gnt_d;
  logic [NOTE_W-1:0]   note_out_q, note_out_d;
  logic                note_en_q, note_en_d;
  logic                switching_q, switching_d;

  logic                mode_valid;
  logic                req_sel;
  logic [NOTE_W-1:0]   note_sel;
  logic [NOTE_W-1:0]   tgt_note;

  assign mode_valid = (mode_q == 3'b001) || (mode_q == 3'b010) || (mode_q == 3'b100);
  assign req_sel    = |(req & mode_cur_q);
  assign tgt_note   = req_sel ? note_sel : '0;

  always_comb begin
    note_sel = '0;
    unique case (mode_cur_q)
      3'b001:  note_sel = note_free;
      3'b010:  note_sel = note_auto;
      3'b100:  note_sel = note_learn;
      default: note_sel = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mode_cur_d = mode_cur_q;
    mute_cnt_d = mute_cnt_q;
    hold_cnt_d = hold_cnt_q;
    note_en_d  = note_en_q;
    note_out_d = note_out_q;

    unique case (state_q)
      StIdle: begin
        if (mode_valid) begin
          mode_cur_d = mode_q;
          mute_cnt_d = MuteLoad;
          state_d    = StMute;
        end
      end
      StMute: begin
        if (!mode_valid) begin
          state_d    = StIdle;
          mode_cur_d = 3'b000;
        end else if (mode_q != mode_cur_q) begin
          mode_cur_d = mode_q;
          mute_cnt_d = MuteLoad;
        end else if (mute_cnt_q == '0) begin
          state_d    = StActive;
          hold_cnt_d = '0;
        end else begin
          mute_cnt_d = mute_cnt_q - 1'b1;
        end
      end
      StActive: begin
        // A mode change pre-empts any pending hold.
        if (!mode_valid) begin
          state_d    = StIdle;
          mode_cur_d = 3'b000;
          note_en_d  = 1'b0;
          note_out_d = '0;
        end else if (mode_q != mode_cur_q) begin
          state_d    = StMute;
          mode_cur_d = mode_q;
          mute_cnt_d = MuteLoad;
          note_en_d  = 1'b0;
          note_out_d = '0;
        end else if (hold_cnt_q != '0) begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end else if ((req_sel != note_en_q) || (tgt_note != note_out_q)) begin
          note_en_d  = req_sel;
          note_out_d = tgt_note;
          hold_cnt_d = HoldLoad;
        end
      end
      default: state_d = StIdle;
    endcase

    gnt_d       = (state_d == StActive) ? mode_cur_d : 3'b000;
    switching_d = (state_d == StMute);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      mode_q      <= 3'b000;
      mode_cur_q  <= 3'b000;
      mute_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      gnt_q       <= 3'b000;
      note_out_q  <= '0;
      note_en_q   <= 1'b0;
      switching_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_in;
      mode_cur_q  <= mode_cur_d;
      mute_cnt_q  <= mute_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      note_out_q  <= note_out_d;
      note_en_q   <= note_en_d;
      switching_q <= switching_d;
    end
  end

  assign gnt       = gnt_q;
  assign note_out  = note_out_q;
  assign note_en   = note_en_q;
  assign mode_cur  = mode_cur_q;
  assign switching = switching_q;

endmodule

// File: tb/tb_tone_channel_arbiter.sv
// Randomised and directed bench for tone_channel_arbiter against a behavioural model.
module tb_tone_channel_arbiter;

  localparam int NW    = 5;
  localparam int MUTE  = 16;
  localparam int HOLD  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [2:0]    mode_in = '0;
  logic [2:0]    req = '0;
  logic [NW-1:0] note_free = '0, note_auto = '0, note_learn = '0;
  logic [2:0]    gnt;
  logic [NW-1:0] note_out;
  logic          note_en;
  logic [2:0]    mode_cur;
  logic          switching;

  int n_checks = 0;
  int n_fail   = 0;

  tone_channel_arbiter #(.NOTE_W(NW), .MUTE_CYCLES(MUTE), .MIN_HOLD(HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode_in    (mode_in),
    .req        (req),
    .note_free  (note_free),
    .note_auto  (note_auto),
    .note_learn (note_learn),
    .gnt        (gnt),
    .note_out   (note_out),
    .note_en    (note_en),
    .mode_cur   (mode_cur),
    .switching  (switching)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase 0 = idle, 1 = silent gap, 2 = channel owned.
  int m_phase, m_mode_seen, m_owner, m_gap_left, m_hold_left, m_en, m_note;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_valid(input int m);
    return (m == 1) || (m == 2) || (m == 4);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_mode_seen = 0; m_owner = 0;
    m_gap_left = 0; m_hold_left = 0; m_en = 0; m_note = 0;
  endtask

  task automatic model_step();
    int src, want_en, want_note;
    int notes[3];
    if (!rst) begin
      model_reset();
      return;
    end
    notes[0] = note_free; notes[1] = note_auto; notes[2] = note_learn;
    if (m_phase == 0) begin
      if (is_valid(m_mode_seen)) begin
        m_owner = m_mode_seen; m_gap_left = MUTE; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (!is_valid(m_mode_seen)) begin
        m_phase = 0; m_owner = 0;
      end else if (m_mode_seen != m_owner) begin
        m_owner = m_mode_seen; m_gap_left = MUTE;
      end else begin
        m_gap_left--;
        if (m_gap_left == 0) begin
          m_phase = 2; m_hold_left = 0;
        end
      end
    end else begin
      if (!is_valid(m_mode_seen) || m_mode_seen != m_owner) begin
        m_en = 0; m_note = 0;
        if (!is_valid(m_mode_seen)) begin
          m_phase = 0; m_owner = 0;
        end else begin
          m_phase = 1; m_owner = m_mode_seen; m_gap_left = MUTE;
        end
      end else if (m_hold_left > 0) begin
        m_hold_left--;
      end else begin
        src       = (m_owner == 1) ? 0 : (m_owner == 2) ? 1 : 2;
        want_en   = req[src];
        want_note = want_en ? notes[src] : 0;
        if (want_en != m_en || want_note != m_note) begin
          m_en = want_en; m_note = want_note; m_hold_left = HOLD - 1;
        end
      end
    end
    m_mode_seen = mode_in;
  endtask

  task automatic compare_all();
    check("gnt", gnt, (m_phase == 2) ? m_owner : 0);
    check("note_en", note_en, m_en);
    check("note_out", note_out, m_note);
    check("mode_cur", mode_cur, m_owner);
    check("switching", switching, (m_phase == 1) ? 1 : 0);
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      compare_all();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, gnt, 0);
    check({tag, "_en"}, note_en, 0);
    check({tag, "_note"}, note_out, 0);
    check({tag, "_mode"}, mode_cur, 0);
    check({tag, "_sw"}, switching, 0);
  endtask

  initial begin
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Startup gap then free-play note
    mode_in = 3'b001; req = 3'b001; note_free = 5;
    tick(1);
    check("sw_latency", switching, 0);
    for (int i = 0; i < MUTE; i++) begin
      tick(1);
      check("gap_len", switching, 1);
    end
    tick(1);
    check("first_active_gnt", gnt, 1);
    check("first_active_en", note_en, 0);
    tick(1);
    check("note_on_en", note_en, 1);
    check("note_on_val", note_out, 5);

    // Short glitch is absorbed by the hold window
    note_free = 9; tick(3);
    note_free = 5; tick(10);
    check("glitch_suppr", note_out, 5);
    note_free = 9; tick(10);
    check("note_change", note_out, 9);

    // Other sources ignored
    req = 3'b110; note_auto = 3; tick(10);
    check("foreign_req_en", note_en, 0);
    check("foreign_req_gnt", gnt, 1);

    // Switch to auto mid-hold
    req = 3'b011; note_free = 5; tick(1);
    mode_in = 3'b010; tick(2);
    check("switch_mute_en", note_en, 0);
    check("switch_mute_sw", switching, 1);
    tick(15);
    check("switch_gap_end", switching, 1);
    tick(1);
    check("auto_gnt", gnt, 2);
    tick(1);
    check("auto_note", note_out, 3);

    // Gap restart on a mode toggle mid-gap, then invalid mode
    mode_in = 3'b001; tick(11);
    mode_in = 3'b100; tick(2);
    check("restart_mode", mode_cur, 4);
    check("restart_sw", switching, 1);
    tick(18);
    check("learn_gnt", gnt, 4);
    mode_in = 3'b011; tick(2);
    check("invalid_mode", mode_cur, 0);
    check("invalid_gnt", gnt, 0);

    // Asynchronous reset mid-note
    mode_in = 3'b001; req = 3'b001; note_free = 7; tick(22);
    check("pre_rst_en", note_en, 1);
    #2 rst = 1'b0;
    #1 check_all_zero("async_note");
    model_reset();
    tick(2);
    #1 rst = 1'b1;
    // Asynchronous reset mid-gap
    mode_in = 3'b010; tick(6);
    check("pre_rst_sw", switching, 1);
    #2 rst = 1'b0;
    #1 check_all_zero("async_gap");
    model_reset();
    mode_in = 3'b000;
    tick(1);
    #1 rst = 1'b1;
    tick(5);
    check("idle_hold", switching, 0);

    // Random traffic; mode changes kept rare so the channel gets owned
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(99) < 2) begin
        case ($urandom_range(4))
          0: mode_in = 3'b001;
          1: mode_in = 3'b010;
          2: mode_in = 3'b100;
          default: mode_in = 3'($urandom);
        endcase
      end
      if ($urandom_range(99) < 15) req = 3'($urandom);
      if ($urandom_range(99) < 20) note_free  = NW'($urandom);
      if ($urandom_range(99) < 20) note_auto  = NW'($urandom);
      if ($urandom_range(99) < 20) note_learn = NW'($urandom);
      tick(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
